ahb_master_ctrl: RTL and testbench

//  AHB-Lite initiator for the ahb_slave_memory bus segment. It turns a valid/ready

---
 rtl/ahb_pkg.sv | 26 ++
 rtl/ahb_wait_watchdog.sv | 37 +++
 rtl/ahb_master_ctrl.sv | 155 +++++++++++++++
 tb/tb_ahb_master_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite encodings and master FSM states
// Purpose: bus encodings for HTRANS/HRESP and the master controller state set.
// Ports: none (package).
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  // Which bus phases are outstanding: address only, both overlapped, data only.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_ADDR      = 2'b01,
    ST_ADDR_DATA = 2'b10,
    ST_DATA      = 2'b11
  } mst_state_t;

endpackage

// File: rtl/ahb_wait_watchdog.sv
// rtl/ahb_wait_watchdog.sv - consecutive wait-state counter with expiry
// Purpose: counts consecutive stalled data-phase cycles and flags the cycle
//          whose closing edge is the TIMEOUT-th stall.
// Ports:
//   i_clk     in  clock
//   i_rst     in  asynchronous active-high reset
//   i_clear   in  restart the count (transfer made progress)
//   i_enable  in  this cycle is a stalled data-phase cycle
//   o_expire  out this stalled cycle reaches TIMEOUT (count also restarts)
module ahb_wait_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] r_count;

  // r_count holds stalls already seen, so expiry is the stall that makes TIMEOUT.
  assign o_expire = i_enable && (r_count == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear || o_expire) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/ahb_master_ctrl.sv
// rtl/ahb_master_ctrl.sv - pipelined AHB-Lite initiator with wait watchdog
// Purpose: converts single read/write commands into NONSEQ transfers whose
//          data phase overlaps the next address phase; one response per command.
// Ports:
//   HCLK, HRESET                      clock, async active-high reset
//   cmd_valid/ready/write/addr/wdata  command stream in
//   HSEL, HADDR, HTRANS, HWRITE       address phase out
//   HWDATA / HRDATA, HREADY, HRESP    data phase
//   rsp_valid/rdata/err/timeout       one-cycle response pulse out
module ahb_master_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              HSEL,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout
);

  import ahb_pkg::*;

  mst_state_t        r_state;
  mst_state_t        w_state_nxt;
  logic              r_live;
  logic [ADDR_W-1:0] r_haddr;
  logic              r_hwrite;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_hwdata;
  logic              r_dp_write;
  logic              r_drop;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_timeout;

  logic w_addr_pend;
  logic w_data_pend;
  logic w_accept;
  logic w_addr_done;
  logic w_data_done;
  logic w_stall;
  logic w_expire;
  logic w_addr_nxt;
  logic w_data_nxt;

  assign w_addr_pend = (r_state == ST_ADDR) || (r_state == ST_ADDR_DATA);
  assign w_data_pend = (r_state == ST_ADDR_DATA) || (r_state == ST_DATA);
  assign w_stall     = w_data_pend && !HREADY;
  assign w_addr_done = w_addr_pend && HREADY;
  assign w_data_done = w_data_pend && HREADY;

  // No accept on the watchdog edge: the bus is being forced back to IDLE.
  assign cmd_ready = r_live && (!w_addr_pend || HREADY) && !w_expire;
  assign w_accept  = cmd_valid && cmd_ready;

  ahb_wait_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk    (HCLK),
    .i_rst    (HRESET),
    .i_clear  (HREADY),
    .i_enable (w_stall),
    .o_expire (w_expire)
  );

  always_comb begin
    w_addr_nxt = w_accept || (w_addr_pend && !HREADY);
    w_data_nxt = w_addr_done || (w_data_pend && !HREADY);
    if (w_expire) begin
      w_addr_nxt = 1'b0;
      w_data_nxt = 1'b0;
    end
    case ({w_addr_nxt, w_data_nxt})
      2'b10:   w_state_nxt = ST_ADDR;
      2'b11:   w_state_nxt = ST_ADDR_DATA;
      2'b01:   w_state_nxt = ST_DATA;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state       <= ST_IDLE;
      r_live        <= 1'b0;
      r_haddr       <= '0;
      r_hwrite      <= 1'b0;
      r_wdata       <= '0;
      r_hwdata      <= '0;
      r_dp_write    <= 1'b0;
      r_drop        <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
      if (w_accept) begin
        r_haddr  <= cmd_addr;
        r_hwrite <= cmd_write;
        r_wdata  <= cmd_wdata;
      end
      // Address phase hands its direction and write data over to the data phase.
      if (w_addr_done) begin
        r_hwdata   <= r_wdata;
        r_dp_write <= r_hwrite;
      end
      // A dropped address phase still owes its requester a (timeout) response.
      r_drop <= w_expire && w_addr_pend;
      if (w_expire || r_drop) begin
        r_rsp_valid   <= 1'b1;
        r_rsp_rdata   <= '0;
        r_rsp_err     <= 1'b1;
        r_rsp_timeout <= 1'b1;
      end else if (w_data_done) begin
        r_rsp_valid   <= 1'b1;
        r_rsp_rdata   <= r_dp_write ? '0 : HRDATA;
        r_rsp_err     <= (hresp_t'(HRESP) == HRESP_ERROR);
        r_rsp_timeout <= 1'b0;
      end else begin
        r_rsp_valid   <= 1'b0;
        r_rsp_rdata   <= '0;
        r_rsp_err     <= 1'b0;
        r_rsp_timeout <= 1'b0;
      end
    end
  end

  assign HSEL        = w_addr_pend;
  assign HTRANS      = w_addr_pend ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR       = r_haddr;
  assign HWRITE      = r_hwrite;
  assign HWDATA      = r_hwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_ahb_master_ctrl.sv
// tb/tb_ahb_master_ctrl.sv - self-checking bench for ahb_master_ctrl
module tb_ahb_master_ctrl;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              HSEL, HWRITE, HREADY, HRESP;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic [DATA_W-1:0] HWDATA, HRDATA;
  logic              rsp_valid, rsp_err, rsp_timeout;
  logic [DATA_W-1:0] rsp_rdata;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  ahb_master_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout)
  );

  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #2;
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    HREADY = 1; HRESP = 0; HRDATA = '0;
  endtask

  task automatic offer(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    HRESET = 0;
    #1 HRESET = 1;
    step(); step();
    checks++;
    if ({HSEL, HTRANS, HADDR, HWRITE, HWDATA} !== '0) begin
      errors++; $display("FAIL reset_bus got=%0h exp=0", {HSEL, HTRANS, HADDR, HWRITE, HWDATA});
    end
    checks++;
    if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready} !== '0) begin
      errors++; $display("FAIL reset_rsp got=%0h exp=0", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready});
    end
    HRESET = 0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_early got=%b exp=0", cmd_ready); end
    step();
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_write_latency();
    offer(1, 10'h010, 32'hDEADBEEF);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL t1_ready got=%b exp=1", cmd_ready); end
    step();
    cmd_valid = 0;
    checks++;
    if ({HSEL, HTRANS, HADDR, HWRITE, rsp_valid} !== {1'b1, 2'b10, 10'h010, 1'b1, 1'b0}) begin
      errors++; $display("FAIL t1_addr_phase got=%0h exp=%0h", {HSEL, HTRANS, HADDR, HWRITE, rsp_valid}, {1'b1, 2'b10, 10'h010, 1'b1, 1'b0});
    end
    step();
    checks++;
    if ({HSEL, HTRANS, HWDATA, rsp_valid} !== {1'b0, 2'b00, 32'hDEADBEEF, 1'b0}) begin
      errors++; $display("FAIL t1_data_phase got=%0h exp=%0h", {HSEL, HTRANS, HWDATA, rsp_valid}, {1'b0, 2'b00, 32'hDEADBEEF, 1'b0});
    end
    step();
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b100, 32'h0}) begin
      errors++; $display("FAIL t1_rsp got=%0h exp=%0h", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {3'b100, 32'h0});
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL t1_pulse got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_error_resp();
    logic [DATA_W-1:0] rd;
    rd = $urandom;
    offer(1, 10'h002, $urandom);
    step();
    cmd_valid = 0;
    step();
    HRESP = 1;
    offer(0, 10'h005, '0);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL t2_ready got=%b exp=1", cmd_ready); end
    step();
    HRESP = 0; cmd_valid = 0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110) begin
      errors++; $display("FAIL t2_err_rsp got=%b exp=110", {rsp_valid, rsp_err, rsp_timeout});
    end
    checks++;
    if ({HTRANS, HADDR, HWRITE} !== {2'b10, 10'h005, 1'b0}) begin
      errors++; $display("FAIL t2_next_addr got=%0h exp=%0h", {HTRANS, HADDR, HWRITE}, {2'b10, 10'h005, 1'b0});
    end
    step();
    HRDATA = rd;
    step();
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, rd}) begin
      errors++; $display("FAIL t2_next_rsp got=%0h exp=%0h", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, rd});
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] d1, d2;
    d1 = $urandom; d2 = $urandom;
    offer(0, 10'h010, '0);
    step();
    offer(0, 10'h011, '0);
    #1;
    checks++;
    if ({cmd_ready, HTRANS, HADDR} !== {1'b1, 2'b10, 10'h010}) begin
      errors++; $display("FAIL t3_first got=%0h exp=%0h", {cmd_ready, HTRANS, HADDR}, {1'b1, 2'b10, 10'h010});
    end
    step();
    cmd_valid = 0; HRDATA = d1;
    checks++;
    if ({HTRANS, HADDR} !== {2'b10, 10'h011}) begin
      errors++; $display("FAIL t3_second got=%0h exp=%0h", {HTRANS, HADDR}, {2'b10, 10'h011});
    end
    step();
    HRDATA = d2;
    checks++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, d1}) begin
      errors++; $display("FAIL t3_rsp1 got=%0h exp=%0h", {rsp_valid, rsp_rdata}, {1'b1, d1});
    end
    step();
    checks++;
    if ({rsp_valid, rsp_rdata, HTRANS} !== {1'b1, d2, 2'b00}) begin
      errors++; $display("FAIL t3_rsp2 got=%0h exp=%0h", {rsp_valid, rsp_rdata, HTRANS}, {1'b1, d2, 2'b00});
    end
    step();
  endtask

  task automatic test_wait_states();
    logic [DATA_W-1:0] da, w1;
    da = $urandom; w1 = $urandom;
    offer(0, 10'h020, '0);
    step();
    offer(1, 10'h021, w1);
    step();
    cmd_valid = 0;
    for (int i = 0; i < 3; i++) begin
      HREADY = 0;
      step();
      checks++;
      if ({HTRANS, HADDR, HWRITE, rsp_valid} !== {2'b10, 10'h021, 1'b1, 1'b0}) begin
        errors++; $display("FAIL t4_addr_hold%0d got=%0h exp=%0h", i, {HTRANS, HADDR, HWRITE, rsp_valid}, {2'b10, 10'h021, 1'b1, 1'b0});
      end
    end
    HREADY = 1; HRDATA = da;
    step();
    checks++;
    if ({rsp_valid, rsp_rdata, HTRANS, HWDATA} !== {1'b1, da, 2'b00, w1}) begin
      errors++; $display("FAIL t4_rsp_read got=%0h exp=%0h", {rsp_valid, rsp_rdata, HTRANS, HWDATA}, {1'b1, da, 2'b00, w1});
    end
    for (int i = 0; i < 3; i++) begin
      HREADY = 0;
      step();
      checks++;
      if ({HWDATA, rsp_valid} !== {w1, 1'b0}) begin
        errors++; $display("FAIL t4_wdata_hold%0d got=%0h exp=%0h", i, {HWDATA, rsp_valid}, {w1, 1'b0});
      end
    end
    HREADY = 1;
    step();
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0}) begin
      errors++; $display("FAIL t4_rsp_write got=%0h exp=%0h", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'h0});
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL t4_single got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_timeout();
    logic [DATA_W-1:0] rd;
    rd = $urandom;
    offer(0, 10'h040, '0);
    step();
    offer(1, 10'h041, $urandom);
    step();
    cmd_valid = 0; HREADY = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      checks++;
      if ({rsp_valid, HTRANS} !== {1'b0, 2'b10}) begin
        errors++; $display("FAIL t5_stall%0d got=%0h exp=%0h", i, {rsp_valid, HTRANS}, {1'b0, 2'b10});
      end
      step();
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout, HTRANS, HSEL} !== {3'b111, 2'b00, 1'b0}) begin
      errors++; $display("FAIL t5_timeout got=%0h exp=%0h", {rsp_valid, rsp_err, rsp_timeout, HTRANS, HSEL}, {3'b111, 2'b00, 1'b0});
    end
    step();
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout, HTRANS} !== {3'b111, 2'b00}) begin
      errors++; $display("FAIL t5_dropped got=%0h exp=%0h", {rsp_valid, rsp_err, rsp_timeout, HTRANS}, {3'b111, 2'b00});
    end
    HREADY = 1;
    step();
    offer(0, 10'h050, '0);
    #1;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL t5_recover_ready got=%b exp=01", {rsp_valid, cmd_ready});
    end
    step();
    cmd_valid = 0;
    step();
    HRDATA = rd;
    step();
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b100, rd}) begin
      errors++; $display("FAIL t5_recover_rsp got=%0h exp=%0h", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {3'b100, rd});
    end
    step();
  endtask

  task automatic test_reset_midflight();
    bit seen;
    seen = 0;
    offer(1, 10'h060, $urandom);
    step();
    cmd_valid = 0;
    step();
    HREADY = 0;
    offer(0, 10'h061, '0);
    step();
    cmd_valid = 0;
    #1 HRESET = 1;
    #1;
    checks++;
    if ({HTRANS, HSEL, rsp_valid, cmd_ready} !== 5'b0) begin
      errors++; $display("FAIL t6_reset_now got=%b exp=00000", {HTRANS, HSEL, rsp_valid, cmd_ready});
    end
    step(); step();
    HRESET = 0; HREADY = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid === 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL t6_lost_rsp got=1 exp=0"); end
  endtask

  task automatic test_random();
    cmd_t pend_q[$];
    cmd_t dp;
    bit dp_active = 0, exp_v = 0, drain;
    logic [DATA_W-1:0] exp_rdata = '0;
    logic exp_err = 0, exp_rdy;
    int stall = 0, n_acc = 0, n_rsp = 0;
    idle_inputs();
    for (int c = 0; c < 600; c++) begin
      checks++;
      if (rsp_valid !== exp_v) begin errors++; $display("FAIL rnd_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, exp_v); end
      if (exp_v && rsp_valid === 1'b1) begin
        n_rsp++;
        checks++;
        if ({rsp_rdata, rsp_err, rsp_timeout} !== {exp_rdata, exp_err, 1'b0}) begin
          errors++; $display("FAIL rnd_rsp c=%0d got=%0h exp=%0h", c, {rsp_rdata, rsp_err, rsp_timeout}, {exp_rdata, exp_err, 1'b0});
        end
      end
      checks++;
      if (HTRANS !== ((pend_q.size() != 0) ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL rnd_htrans c=%0d got=%b pending=%0d", c, HTRANS, pend_q.size());
      end
      drain = (c >= 560);
      if (stall >= 5 || drain) HREADY = 1;
      else HREADY = ($urandom_range(0, 3) != 0);
      stall = HREADY ? 0 : stall + 1;
      HRESP = ($urandom_range(0, 9) == 0);
      HRDATA = $urandom;
      cmd_valid = !drain && ($urandom_range(0, 9) < 7);
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr = ADDR_W'($urandom);
      cmd_wdata = $urandom;
      #1;
      exp_rdy = (pend_q.size() == 0) || HREADY;
      checks++;
      if (cmd_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, cmd_ready, exp_rdy); end
      exp_v = 0;
      if (dp_active && HREADY) begin
        if (dp.write) begin
          checks++;
          if (HWDATA !== dp.wdata) begin errors++; $display("FAIL rnd_hwdata c=%0d got=%0h exp=%0h", c, HWDATA, dp.wdata); end
        end
        exp_v = 1;
        exp_rdata = dp.write ? '0 : HRDATA;
        exp_err = HRESP;
        dp_active = 0;
      end
      if (pend_q.size() != 0 && HREADY) begin
        checks++;
        if ({HADDR, HWRITE} !== {pend_q[0].addr, pend_q[0].write}) begin
          errors++; $display("FAIL rnd_addr c=%0d got=%0h exp=%0h", c, {HADDR, HWRITE}, {pend_q[0].addr, pend_q[0].write});
        end
        dp = pend_q.pop_front();
        dp_active = 1;
      end
      if (cmd_valid && cmd_ready) begin
        pend_q.push_back('{addr: cmd_addr, write: cmd_write, wdata: cmd_wdata});
        n_acc++;
      end
      step();
    end
    idle_inputs();
    checks++;
    if (n_rsp != n_acc || n_acc == 0) begin
      errors++; $display("FAIL rnd_count got=%0d responses exp=%0d", n_rsp, n_acc);
    end
  endtask

  initial begin
    test_reset();
    test_write_latency();
    test_error_resp();
    test_back_to_back();
    test_wait_states();
    test_timeout();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
